// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr -- round-robin Wishbone B3 arbiter.
//
// Lets num_masters masters share one Wishbone master port that feeds wb_mux.
// A master owns the bus for its whole cycle (cyc high, bursts included). When
// the owner drops cyc, the grant passes straight to the next requester in
// round-robin order, so there is no idle cycle between owners. Slave responses
// go back to the owner only.
//
// Ports
//   wb_clk_i, wb_rst_ni               clock, asynchronous active-low reset
//   wbm_*_i                           concatenated master requests, master k
//                                     occupies slice k of each bus
//   wbm_dat_o                         read data, broadcast to every master
//   wbm_ack_o / wbm_err_o / wbm_rty_o responses, only the owner's bit can be set
//   wbs_*_o                           the owner's request, gated by grant
//   wbs_dat_i/ack_i/err_i/rty_i       slave response from wb_mux
module wb_arbiter_rr #(
   parameter int num_masters = 2,
   parameter int aw          = 32,
   parameter int dw          = 32
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_ni,
   input  logic [num_masters*aw-1:0] wbm_adr_i,
   input  logic [num_masters*dw-1:0] wbm_dat_i,
   input  logic [num_masters*dw/8-1:0] wbm_sel_i,
   input  logic [num_masters-1:0]    wbm_we_i,
   input  logic [num_masters-1:0]    wbm_cyc_i,
   input  logic [num_masters-1:0]    wbm_stb_i,
   input  logic [num_masters*3-1:0]  wbm_cti_i,
   input  logic [num_masters*2-1:0]  wbm_bte_i,
   output logic [num_masters*dw-1:0] wbm_dat_o,
   output logic [num_masters-1:0]    wbm_ack_o,
   output logic [num_masters-1:0]    wbm_err_o,
   output logic [num_masters-1:0]    wbm_rty_o,
   output logic [aw-1:0]             wbs_adr_o,
   output logic [dw-1:0]             wbs_dat_o,
   output logic [dw/8-1:0]           wbs_sel_o,
   output logic                      wbs_we_o,
   output logic                      wbs_cyc_o,
   output logic                      wbs_stb_o,
   output logic [2:0]                wbs_cti_o,
   output logic [1:0]                wbs_bte_o,
   input  logic [dw-1:0]             wbs_dat_i,
   input  logic                      wbs_ack_i,
   input  logic                      wbs_err_i,
   input  logic                      wbs_rty_i
);

   localparam int iw = (num_masters > 1) ? $clog2(num_masters) : 1;
   localparam int sw = dw / 8;

   if (num_masters < 2 || num_masters > 8) begin : g_param_check
      $error("wb_arbiter_rr: num_masters must be within 2..8");
   end

   typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

   state_t                 state, state_nxt;
   logic [iw-1:0]          owner, owner_nxt;
   logic [iw-1:0]          last, last_nxt;
   logic [num_masters-1:0] others;
   logic                   grant_valid;

   // First requester after base, scanning base+1, base+2, ... and wrapping;
   // base itself is the last candidate. Iterating from the far end keeps the
   // nearest requester as the final assignment, so no early exit is needed.
   function automatic logic [iw-1:0] rr_pick(input logic [num_masters-1:0] req,
                                             input logic [iw-1:0]          base);
      logic [iw-1:0] pick;
      int            idx;
      pick = base;
      for (int i = num_masters; i >= 1; i--) begin
         idx = int'(base) + i;
         if (idx >= num_masters) idx = idx - num_masters;
         if (req[idx]) pick = iw'(idx);
      end
      return pick;
   endfunction

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state <= IDLE;
         owner <= '0;
         last  <= iw'(num_masters - 1);
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      // Requests excluding the current owner: a master that drops cyc and
      // re-raises it in the same cycle is skipped once.
      others    = wbm_cyc_i & ~({{(num_masters-1){1'b0}}, 1'b1} << owner);
      case (state)
         IDLE: begin
            if (|wbm_cyc_i) begin
               state_nxt = GRANTED;
               owner_nxt = rr_pick(wbm_cyc_i, last);
            end
         end
         GRANTED: begin
            if (!wbm_cyc_i[owner]) begin
               last_nxt = owner;
               // Hand over directly; grant_valid stays high, no idle cycle.
               if (|others) owner_nxt = rr_pick(others, owner);
               else         state_nxt = IDLE;
            end
         end
      endcase
   end

   assign grant_valid = (state == GRANTED);

   // Request path: pure mux on owner, zero added latency.
   assign wbs_adr_o = wbm_adr_i[int'(owner)*aw +: aw];
   assign wbs_dat_o = wbm_dat_i[int'(owner)*dw +: dw];
   assign wbs_sel_o = wbm_sel_i[int'(owner)*sw +: sw];
   assign wbs_cti_o = wbm_cti_i[int'(owner)*3 +: 3];
   assign wbs_bte_o = wbm_bte_i[int'(owner)*2 +: 2];
   assign wbs_we_o  = wbm_we_i[owner];
   assign wbs_cyc_o = wbm_cyc_i[owner] & grant_valid;
   assign wbs_stb_o = wbm_stb_i[owner] & grant_valid;

   // Response path: data broadcast, handshakes routed to the owner only and
   // dropped entirely while no grant is held.
   assign wbm_dat_o = {num_masters{wbs_dat_i}};

   for (genvar k = 0; k < num_masters; k++) begin : g_resp
      logic is_owner;
      assign is_owner     = grant_valid & (owner == iw'(k));
      assign wbm_ack_o[k] = wbs_ack_i & is_owner;
      assign wbm_err_o[k] = wbs_err_i & is_owner;
      assign wbm_rty_o[k] = wbs_rty_i & is_owner;
   end

endmodule
